// File: rtl/vga_mem_pkg.sv
// Shared definitions for the framebuffer memory slice.
// Contents:
//   clr_state_t - clear engine state encoding (IDLE / CLEAR / DONE)
//   B_PIPE_MAX  - highest supported number of extra port B output stages
package vga_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  localparam int unsigned B_PIPE_MAX = 1;

endpackage : vga_mem_pkg

// File: rtl/vga_fb_mem_if.sv
// Bus bundle for the framebuffer memory.
// Port A (draw side): a_addr, a_data, a_we in; a_ready, q_a out.
// Port B (scanout):   b_addr, b_en in; q_b out.
// Clear control:      clr_start in; clr_busy, clr_done out.
// master = requester side, slave = memory side.
interface vga_fb_mem_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_we;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] q_a;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_en;
  logic [DATA_WIDTH-1:0] q_b;
  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output a_addr, a_data, a_we, b_addr, b_en, clr_start,
    input  a_ready, q_a, q_b, clr_busy, clr_done
  );

  modport slave (
    input  a_addr, a_data, a_we, b_addr, b_en, clr_start,
    output a_ready, q_a, q_b, clr_busy, clr_done
  );

endinterface : vga_fb_mem_if

// File: rtl/vga_fb_clear_ctrl.sv
// Clear engine: sweeps every word to CLEAR_VALUE and owns port A admission.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   a_addr, a_data, a_we     - port A write request
//   clr_start                - start a full clear (ignored unless idle)
//   a_ready, clr_busy        - registered status (idle / sweeping)
//   clr_done                 - registered one-cycle pulse after the last clear write
//   wr_en_c, wr_addr_c,
//   wr_data_c                - combinational internal write port to the RAM core
module vga_fb_clear_ctrl
  import vga_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           DEPTH       = 1024,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_we,
  input  logic                  clr_start,
  output logic                  a_ready,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_en_c,
  output logic [ADDR_WIDTH-1:0] wr_addr_c,
  output logic [DATA_WIDTH-1:0] wr_data_c
);

  // One extra bit so the terminal compare never aliases through a wrap.
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  clr_state_t       state;
  logic [PTR_W-1:0] ptr;

  // State, pointer and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      a_ready  <= 1'b1;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            a_ready  <= 1'b0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          ptr <= ptr + PTR_W'(1);
          if (ptr == LAST_PTR) begin
            state    <= ST_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          clr_done <= 1'b0;
          a_ready  <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          a_ready  <= 1'b1;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Internal write mux: the sweep owns the RAM while clearing, else port A.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = a_addr;
    wr_data_c = a_data;
    if (state == ST_CLEAR) begin
      wr_en_c   = 1'b1;
      wr_addr_c = ptr[ADDR_WIDTH-1:0];
      wr_data_c = CLEAR_VALUE;
    end else if (a_ready && a_we) begin
      wr_en_c = 1'b1;
    end
  end

endmodule : vga_fb_clear_ctrl

// File: rtl/vga_fb_mem.sv
// Dual-port framebuffer with hardware clear.
// Ports:
//   clk, rst - clock, async active-high reset
//   bus      - vga_fb_mem_if slave: port A read/write, port B read-only
//              scanout with write forwarding, clear start/busy/done
// Out-of-range addresses (>= DEPTH) drop writes and read as zero.
module vga_fb_mem
  import vga_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           DEPTH       = 1024,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int unsigned           B_PIPE      = 0
) (
  input logic         clk,
  input logic         rst,
  vga_fb_mem_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_WIDTH + 1;
  localparam logic [CMP_W-1:0] DEPTH_CMP = CMP_W'(DEPTH);

  if (B_PIPE > B_PIPE_MAX) begin : g_bad_pipe
    $error("vga_fb_mem: B_PIPE must be 0 or 1");
  end
  if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("vga_fb_mem: DEPTH exceeds the address space");
  end

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic                  a_ready;
  logic                  wr_in_c;
  logic                  wr_ok_c;
  logic                  a_in_c;
  logic                  b_in_c;
  logic                  a_acc_c;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] b_s1;

  vga_fb_clear_ctrl #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH       (DEPTH),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .a_addr    (bus.a_addr),
    .a_data    (bus.a_data),
    .a_we      (bus.a_we),
    .clr_start (bus.clr_start),
    .a_ready   (a_ready),
    .clr_busy  (bus.clr_busy),
    .clr_done  (bus.clr_done),
    .wr_en_c   (wr_en_c),
    .wr_addr_c (wr_addr_c),
    .wr_data_c (wr_data_c)
  );

  assign bus.a_ready = a_ready;

  // Range qualifiers use the full address width against DEPTH.
  assign a_in_c  = ({1'b0, bus.a_addr} < DEPTH_CMP);
  assign b_in_c  = ({1'b0, bus.b_addr} < DEPTH_CMP);
  assign wr_in_c = ({1'b0, wr_addr_c} < DEPTH_CMP);
  assign wr_ok_c = wr_en_c && wr_in_c;
  assign a_acc_c = a_ready && bus.a_we;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      ram[wr_addr_c[IDX_W-1:0]] <= wr_data_c;
    end
  end

  // Port A, write-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a <= '0;
    end else if (!a_in_c) begin
      q_a <= '0;
    end else if (a_acc_c) begin
      q_a <= bus.a_data;
    end else begin
      q_a <= ram[bus.a_addr[IDX_W-1:0]];
    end
  end

  assign bus.q_a = q_a;

  // Port B first stage with forwarding of the same-cycle internal write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_s1 <= '0;
    end else if (bus.b_en) begin
      if (wr_ok_c && (wr_addr_c == bus.b_addr)) begin
        b_s1 <= wr_data_c;
      end else if (b_in_c) begin
        b_s1 <= ram[bus.b_addr[IDX_W-1:0]];
      end else begin
        b_s1 <= '0;
      end
    end
  end

  // Optional second stage, advancing only on enabled reads.
  if (B_PIPE == 1) begin : g_b_pipe
    logic [DATA_WIDTH-1:0] b_s2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        b_s2 <= '0;
      end else if (bus.b_en) begin
        b_s2 <= b_s1;
      end
    end
    assign bus.q_b = b_s2;
  end else begin : g_b_direct
    assign bus.q_b = b_s1;
  end

endmodule : vga_fb_mem

// File: doc/vga_fb_mem.md
# vga_fb_mem

Parametrised dual-port framebuffer memory with a built-in hardware clear engine. Port A is the read/write port used by game/draw logic; port B is the read-only scanout port used by the VGA timing path. A clear FSM sweeps every word to a programmable value without external sequencing, stalling port A for the duration. Port B keeps reading at all times and sees same-cycle writes through forwarding.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 16, address width in bits
- DEPTH, 1024, number of implemented words; must be ≤ 2**ADDR_WIDTH
- CLEAR_VALUE, 0, word written by the clear engine; DATA_WIDTH bits
- B_PIPE, 0, extra output register stages on port B; legal values 0 or 1
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- a_addr  in  ADDR_WIDTH  port A address
- a_data  in  DATA_WIDTH  port A write data
- a_we  in  1  port A write enable; accepted only when a_ready=1
- a_ready  out  1  high when port A accepts writes; low while clearing
- q_a  out  DATA_WIDTH  port A read data
- b_addr  in  ADDR_WIDTH  port B address
- b_en  in  1  port B read enable; q_b holds its value when low
- q_b  out  DATA_WIDTH  port B read data
- clr_start  in  1  single-cycle request to start a full clear
- clr_busy  out  1  high while the clear FSM is in CLEAR
- clr_done  out  1  one-cycle pulse after the last clear write

## Operation
- FSM states: IDLE, CLEAR, DONE.
  - IDLE → CLEAR on clr_start; the clear pointer loads 0.
  - CLEAR writes CLEAR_VALUE to ram[ptr], one word per cycle. ptr increments each cycle. After the write at ptr = DEPTH-1 the FSM goes to DONE.
  - DONE lasts one cycle, asserts clr_done, then returns to IDLE.
- clr_start in CLEAR or DONE is ignored. It is not queued.
- a_ready = (state == IDLE). a_we while a_ready=0 is dropped silently; the requester must retry.
- clr_start and a_we in the same IDLE cycle: the A write commits, and the clear starts the next cycle and overwrites it.
- Port A behaves write-first. On an accepted write, q_a takes a_data. Otherwise q_a takes ram[a_addr]. During CLEAR, port A reads continue normally.
- Port B forwarding source each cycle is the internal write (address, data): the accepted A write, or the clear write.
  - If b_en=1, b_addr equals the write address and a write occurs, q_b is loaded with the write data.
  - Otherwise, if b_en=1, q_b is loaded with ram[b_addr].
- Out-of-range address (≥ DEPTH): writes are discarded; reads return 0 on both ports.
- Memory contents are not reset and have no initial-content guarantee. Software issues clr_start after reset.
- Width rules: the clear pointer is ADDR_WIDTH+1 bits so terminal detection cannot wrap; address compares use the full ADDR_WIDTH.

## Timing
- Reset values: q_a=0, q_b=0 (including the B_PIPE stage), clr_busy=0, clr_done=0, a_ready=1, FSM=IDLE, ptr=0.
- Reset asserted mid-clear aborts the sweep immediately. Partially cleared memory is left as is.
- q_a latency: 1 cycle from a_addr/a_we.
- q_b latency: 1+B_PIPE cycles from b_addr. With B_PIPE=1 the second stage also advances only when b_en is high.
- Clear sequence:
  - clr_start sampled at edge N.
  - clr_busy=1 and a_ready=0 from N+1 through N+DEPTH.
  - clr_done=1 during cycle N+DEPTH+1, with a_ready still 0.
  - a_ready returns to 1 at N+DEPTH+2.
- Write visibility: a write at edge N is readable via RAM by port A or B at edge N+1. On port B it is also visible at edge N through forwarding.

## Structure
- Package vga_mem_pkg holds the FSM state encoding (IDLE/CLEAR/DONE) and the B_PIPE legal-range check constant.
- One sub-module, vga_fb_clear_ctrl, contains the FSM, the pointer, a_ready, clr_busy and clr_done. It outputs the muxed internal write port (we, addr, data) to the RAM core in vga_fb_mem.
- The RAM array and port B forwarding stay in the top module.

## Test plan
- Reset then write/read: assert rst mid-simulation, confirm q_a=q_b=0 and a_ready=1. Write 0xA5 @0x010, then read on A next cycle → q_a=0xA5.
- Forwarding: A writes 0x3C @0x020 while b_addr=0x020, b_en=1 → q_b=0x3C the same edge (B_PIPE=0), and one edge later with B_PIPE=1.
- Full clear, DEPTH=16, CLEAR_VALUE=0x7E: pulse clr_start → clr_busy high for 16 cycles, clr_done pulse at cycle 17, then all 16 words read 0x7E on B.
- Stall: during clear, a_we @0x005 with 0x11 → a_ready=0, write dropped, word reads 0x7E after done. A clr_start during the clear does not extend it.
- Simultaneous clr_start + a_we @0x002=0x99 in IDLE → word ends as CLEAR_VALUE.
- Abort and range: rst asserted at clear cycle 5 → FSM IDLE, words 0–4 cleared and 5+ unchanged. A write to address DEPTH is discarded, and a read there returns 0.
